// File: rtl/risc23_pkg.sv
// Shared IITB-RISC-23 pipeline types: fetch FSM states, widths and the
// IF/ID pipeline record that the decode stage also consumes.
package risc23_pkg;

  localparam int          INSTR_W = 16;
  localparam int          PC_W    = 16;
  localparam logic [15:0] PC_INC  = 16'd2;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus2;
  } ifid_t;

  // Sequential successor of a byte address; the carry is dropped so the
  // address space wraps from 16'hFFFE to 16'h0000.
  function automatic logic [PC_W-1:0] pc_succ(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

  // Instructions are halfword aligned: force bit 0 low.
  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory, control and IF/ID signals.
// master: the fetch stage itself; slave: memory plus later pipeline stages.
interface if_stage_if;
  import risc23_pkg::*;

  logic [PC_W-1:0]    pc_byte;
  logic [INSTR_W-1:0] instr;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt;
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic [PC_W-1:0]    ifid_pc_plus2;
  logic               halted;
  logic               misalign_err;
  logic [15:0]        fetch_count;

  modport master (
    output pc_byte,
    input  instr,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc,
    output ifid_pc_plus2,
    output halted,
    output misalign_err,
    output fetch_count
  );

  modport slave (
    input  pc_byte,
    output instr,
    output stall,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_pc_plus2,
    input  halted,
    input  misalign_err,
    input  fetch_count
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. squash clears only the valid bit (payload is kept
// so a bubble still shows the last instruction); squash beats load.
module if_id_reg
  import risc23_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  squash,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t q_reg;

  // Load, squash or hold the pipeline record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (squash) begin
      q_reg.valid <= 1'b0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// captures the returned instruction into IF/ID, and applies redirect / halt /
// stall control (in that priority) from later stages.
module if_stage
  import risc23_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.master  bus
);

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     fetch_count_reg, fetch_count_next;
  logic            misalign_reg, misalign_next;
  logic            ifid_load, ifid_squash;
  ifid_t           ifid_d, ifid_q;

  // State, PC, counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      fetch_count_reg <= '0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fetch_count_reg <= fetch_count_next;
      misalign_reg    <= misalign_next;
    end
  end

  // Next-state and IF/ID control; redirect outranks halt and stall because
  // those would come from a younger instruction that the redirect squashes.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    fetch_count_next = fetch_count_reg;
    misalign_next    = misalign_reg;
    ifid_load        = 1'b0;
    ifid_squash      = 1'b0;

    ifid_d.valid     = 1'b1;
    ifid_d.instr     = bus.instr;
    ifid_d.pc        = pc_reg;
    ifid_d.pc_plus2  = pc_succ(pc_reg);

    unique case (state_reg)
      RUN: begin
        if (bus.redirect_valid) begin
          pc_next     = pc_align(bus.redirect_pc);
          ifid_squash = 1'b1;
          if (bus.redirect_pc[0]) begin
            misalign_next = 1'b1;
          end
        end else if (bus.halt) begin
          state_next  = HALTED;
          ifid_squash = 1'b1;
        end else if (bus.stall) begin
          // Hold everything.
        end else begin
          ifid_load        = 1'b1;
          pc_next          = pc_succ(pc_reg);
          fetch_count_next = fetch_count_reg + 16'd1;
        end
      end
      HALTED: begin
        // Frozen until reset.
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .squash (ifid_squash),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign bus.pc_byte       = pc_reg;
  assign bus.ifid_valid    = ifid_q.valid;
  assign bus.ifid_instr    = ifid_q.instr;
  assign bus.ifid_pc       = ifid_q.pc;
  assign bus.ifid_pc_plus2 = ifid_q.pc_plus2;
  assign bus.halted        = (state_reg == HALTED);
  assign bus.misalign_err  = misalign_reg;
  assign bus.fetch_count   = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a combinational memory model.
module tb_if_stage;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  if_stage_if bus ();

  if_stage #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: three fixed words at 0/2/4, everything else addr ^ 16'hA5A5.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1000;
      16'h0002: return 16'h2000;
      16'h0004: return 16'h3000;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  always_comb bus.instr = mem_f(bus.pc_byte);

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] redir_pc;
    logic        halt;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_plus2;
    logic [15:0] e_pcb;
    logic [15:0] e_cnt;
    logic        e_halted;
    logic        e_mis;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " ifid_valid"},    {15'd0, bus.ifid_valid},   {15'd0, v.e_valid});
    chk({tag, " ifid_instr"},    bus.ifid_instr,            v.e_instr);
    chk({tag, " ifid_pc"},       bus.ifid_pc,               v.e_pc);
    chk({tag, " ifid_pc_plus2"}, bus.ifid_pc_plus2,         v.e_plus2);
    chk({tag, " pc_byte"},       bus.pc_byte,               v.e_pcb);
    chk({tag, " fetch_count"},   bus.fetch_count,           v.e_cnt);
    chk({tag, " halted"},        {15'd0, bus.halted},       {15'd0, v.e_halted});
    chk({tag, " misalign_err"},  {15'd0, bus.misalign_err}, {15'd0, v.e_mis});
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rp, input logic h,
                              input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                              input logic [15:0] e2, input logic [15:0] eb, input logic [15:0] ec,
                              input logic eh, input logic em);
    vec_t v;
    v.stall = s; v.redir = r; v.redir_pc = rp; v.halt = h;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_plus2 = e2;
    v.e_pcb = eb; v.e_cnt = ec; v.e_halted = eh; v.e_mis = em;
    return v;
  endfunction

  vec_t rst_v;

  initial begin
    n_total = 0;
    n_pass  = 0;
    //              stall redir rpc       halt  val instr     pc        plus2     pc_byte   cnt    hlt mis
    vecs[0]  = mk(0, 0, 16'h0000, 0,  1, 16'h1000, 16'h0000, 16'h0002, 16'h0002, 16'd1, 0, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 0,  1, 16'h2000, 16'h0002, 16'h0004, 16'h0004, 16'd2, 0, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0,  1, 16'h3000, 16'h0004, 16'h0006, 16'h0006, 16'd3, 0, 0);
    vecs[3]  = mk(1, 0, 16'h0000, 0,  1, 16'h3000, 16'h0004, 16'h0006, 16'h0006, 16'd3, 0, 0);
    vecs[4]  = mk(1, 0, 16'h0000, 0,  1, 16'h3000, 16'h0004, 16'h0006, 16'h0006, 16'd3, 0, 0);
    vecs[5]  = mk(1, 0, 16'h0000, 0,  1, 16'h3000, 16'h0004, 16'h0006, 16'h0006, 16'd3, 0, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 0,  1, 16'hA5A3, 16'h0006, 16'h0008, 16'h0008, 16'd4, 0, 0);
    vecs[7]  = mk(1, 1, 16'h0040, 1,  0, 16'hA5A3, 16'h0006, 16'h0008, 16'h0040, 16'd4, 0, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0,  1, 16'hA5E5, 16'h0040, 16'h0042, 16'h0042, 16'd5, 0, 0);
    vecs[9]  = mk(0, 1, 16'h0043, 0,  0, 16'hA5E5, 16'h0040, 16'h0042, 16'h0042, 16'd5, 0, 1);
    vecs[10] = mk(0, 0, 16'h0000, 0,  1, 16'hA5E7, 16'h0042, 16'h0044, 16'h0044, 16'd6, 0, 1);
    vecs[11] = mk(0, 1, 16'hFFFE, 0,  0, 16'hA5E7, 16'h0042, 16'h0044, 16'hFFFE, 16'd6, 0, 1);
    vecs[12] = mk(0, 0, 16'h0000, 0,  1, 16'h5A5B, 16'hFFFE, 16'h0000, 16'h0000, 16'd7, 0, 1);
    vecs[13] = mk(0, 0, 16'h0000, 0,  1, 16'h1000, 16'h0000, 16'h0002, 16'h0002, 16'd8, 0, 1);
    vecs[14] = mk(0, 0, 16'h0000, 1,  0, 16'h1000, 16'h0000, 16'h0002, 16'h0002, 16'd8, 1, 1);
    vecs[15] = mk(1, 0, 16'h0000, 0,  0, 16'h1000, 16'h0000, 16'h0002, 16'h0002, 16'd8, 1, 1);
    vecs[16] = mk(0, 1, 16'h0081, 0,  0, 16'h1000, 16'h0000, 16'h0002, 16'h0002, 16'd8, 1, 1);
    vecs[17] = mk(0, 0, 16'h0000, 0,  0, 16'h1000, 16'h0000, 16'h0002, 16'h0002, 16'd8, 1, 1);
    rst_v    = mk(0, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd0, 0, 0);

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.halt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", rst_v);
    $display("reset: pc_byte=%h valid=%b", bus.pc_byte, bus.ifid_valid);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      bus.stall          = vecs[i].stall;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].redir_pc;
      bus.halt           = vecs[i].halt;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i]);
      $display("vec%0d: st=%b rd=%b rpc=%h h=%b -> pc_byte=%h v=%b instr=%h pc=%h cnt=%0d halted=%b mis=%b",
               i, vecs[i].stall, vecs[i].redir, vecs[i].redir_pc, vecs[i].halt, bus.pc_byte,
               bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.fetch_count, bus.halted, bus.misalign_err);
      @(negedge clk);
    end

    // Asynchronous reset while halted, taking effect before any clock edge.
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", rst_v);
    $display("async_rst: pc_byte=%h halted=%b mis=%b", bus.pc_byte, bus.halted, bus.misalign_err);

    // First valid IF/ID comes on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst", mk(0, 0, 16'h0000, 0, 1, 16'h1000, 16'h0000, 16'h0002, 16'h0002, 16'd1, 0, 0));
    $display("post_rst: instr=%h pc_byte=%h cnt=%0d", bus.ifid_instr, bus.pc_byte, bus.fetch_count);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the IITB-RISC-23 pipeline. It owns the program counter and drives the byte address into the combinational instruction memory. It captures the returned 16-bit instruction into the IF/ID pipeline register. It also applies stall, redirect (branch/jump/flush) and halt control arriving from later stages.

## Interface
Parameters:
- RESET_PC, 16'h0000, byte address fetched first after reset; bit 0 must be 0.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- pc_byte  output  16  byte address to instruction memory (driven straight from PC register)
- instr  input  16  instruction returned combinationally for pc_byte
- stall  input  1  hold PC and IF/ID contents (load-use hazard)
- redirect_valid  input  1  replace PC and squash IF/ID
- redirect_pc  input  16  new byte address
- halt  input  1  stop fetching; sticky until reset
- ifid_valid  output  1  IF/ID holds a live instruction
- ifid_instr  output  16  captured instruction
- ifid_pc  output  16  byte address of ifid_instr
- ifid_pc_plus2  output  16  ifid_pc + 2, mod 2^16
- halted  output  1  state == HALTED
- misalign_err  output  1  sticky: a redirect_pc with bit 0 set was accepted
- fetch_count  output  16  count of instructions loaded into IF/ID with valid=1, wraps

## Operation
- States: RUN, HALTED. Reset enters RUN.
- Event priority each cycle in RUN, highest first: redirect_valid, halt, stall, normal.
- Redirect:
  - PC <= {redirect_pc[15:1],1'b0}.
  - ifid_valid <= 0; other IF/ID fields hold their values.
  - If redirect_pc[0]=1, misalign_err <= 1.
  - Any halt or stall asserted in the same cycle is ignored, because it comes from a squashed younger instruction.
- Halt, with no redirect:
  - State <= HALTED; ifid_valid <= 0; PC holds.
- Stall, with no redirect or halt:
  - PC and all IF/ID fields hold; ifid_valid unchanged.
- Normal:
  - ifid_instr <= instr; ifid_pc <= PC; ifid_pc_plus2 <= PC+2.
  - ifid_valid <= 1; PC <= PC+2; fetch_count <= fetch_count+1.
- HALTED:
  - All inputs ignored; PC, IF/ID fields and fetch_count frozen; ifid_valid stays 0.
  - Exit is by rst only.
- Arithmetic: all adds are 16-bit unsigned and discard the carry, so 16'hFFFE+2 = 16'h0000.
- fetch_count increments only on the normal path and wraps 16'hFFFF -> 0.

## Timing
- Reset values:
  - PC = RESET_PC, so pc_byte = RESET_PC.
  - ifid_valid = 0, ifid_instr = 0, ifid_pc = 0, ifid_pc_plus2 = 0.
  - halted = 0, misalign_err = 0, fetch_count = 0.
- Reset mid-operation: all state returns to the reset values immediately, independent of clk.
- Latency:
  - The instruction at address A appears on ifid_instr one edge after pc_byte = A, if no stall, redirect or halt occurs at that edge.
  - First valid IF/ID is at the first rising edge after rst deasserts.
- Redirect penalty: a one-cycle bubble (ifid_valid=0). The target instruction is valid in IF/ID on the second edge after redirect_valid is sampled.
- Stall of N cycles: IF/ID output is stable for N cycles, then advances normally; no instruction is lost or duplicated.
- All control inputs are sampled only at the rising edge; there is no combinational path from stall, redirect or halt to pc_byte.

## Structure
- Shared package risc23_pkg:
  - fetch_state_t enum {RUN, HALTED}.
  - INSTR_W=16, PC_W=16, PC_INC=16'd2.
  - A struct ifid_t {valid, instr, pc, pc_plus2} reused by the decode stage.
- Sub-module if_id_reg: holds ifid_t with load/hold/squash controls. The PC register, state machine and counter stay in if_stage.
- Top-level wiring: if_stage.pc_byte -> instr_mem.pc_byte, and instr_mem.instr -> if_stage.instr.

## Test plan
- Reset then free-run with memory 0x1000, 0x2000, 0x3000 at 0, 2, 4 -> ifid_instr = 0x1000/0x2000/0x3000 on edges 1/2/3; ifid_pc = 0/2/4; fetch_count = 3.
- Stall held 3 cycles while IF/ID holds the instruction at 0x0004 -> outputs frozen, pc_byte stays 0x0006; on release, the instruction at 0x0006 is loaded next; fetch_count does not advance during the stall.
- Redirect to 0x0040 asserted together with stall and halt -> ifid_valid=0 and PC=0x0040 next edge; state remains RUN; the instruction at 0x0040 is valid one edge later.
- Redirect to 0x0043 -> PC=0x0042 and misalign_err=1, which stays set until rst.
- PC at 0xFFFE in normal flow -> ifid_pc=0xFFFE, ifid_pc_plus2=0x0000, next pc_byte=0x0000.
- Halt asserted -> halted=1 and ifid_valid=0 next edge; later stall and redirect have no effect; asserting rst mid-cycle restores pc_byte=RESET_PC and halted=0 without waiting for clk.
